i2s_dac_tx: RTL and testbench

//   Stereo I2S transmitter: takes processed sample pairs from the effect chain (chorus output) and

---
 rtl/i2s_dac_tx.sv | 150 +++++++++++++++
 tb/tb_i2s_dac_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// Stereo I2S transmitter: BCLK/LRCLK generation, one-pair shadow buffer, MSB-first serialiser.
// Output pins change only when the internal BCLK divider fires; every output is a flop.
module i2s_dac_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] audio_left_in,
  input  logic [DATA_WIDTH-1:0] audio_right_in,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  dacdat,
  output logic                  sample_req,
  output logic                  underrun,
  output logic                  overrun
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_SZ  = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  bclk_q, bclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  dacdat_q, dacdat_d;
  logic                  sample_req_q, sample_req_d;
  logic                  underrun_q, underrun_d;
  logic                  overrun_q, overrun_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] shadow_l_q, shadow_l_d;
  logic [DATA_WIDTH-1:0] shadow_r_q, shadow_r_d;
  logic [DATA_WIDTH-1:0] active_l_q, active_l_d;
  logic [DATA_WIDTH-1:0] active_r_q, active_r_d;

  logic                  div_tick;
  logic                  bclk_fall;
  logic [BIT_W-1:0]      bit_nxt;
  logic                  lr_nxt;
  logic [BIT_W-1:0]      slot_pos;
  logic                  frame_load;
  logic [DATA_WIDTH-1:0] tx_word;
  logic                  tx_bit;

  always_comb begin
    div_tick   = (div_cnt_q == DIV_LAST);
    bclk_fall  = div_tick & bclk_q;
    bit_nxt    = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
    lr_nxt     = (bit_nxt >= SLOT_SZ);
    slot_pos   = lr_nxt ? (bit_nxt - SLOT_SZ) : bit_nxt;
    frame_load = bclk_fall && (bit_nxt == '0);
    tx_word    = lr_nxt ? active_r_q : active_l_q;

    // Slot position 0 is the one-BCLK I2S delay; positions past the sample are zero padding.
    tx_bit = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (slot_pos == BIT_W'(DATA_WIDTH - i)) begin
        tx_bit = tx_word[i];
      end
    end
  end

  always_comb begin
    div_cnt_d    = div_tick ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d       = bclk_q ^ div_tick;
    bit_cnt_d    = bit_cnt_q;
    lrclk_d      = lrclk_q;
    dacdat_d     = dacdat_q;
    sample_req_d = 1'b0;
    underrun_d   = 1'b0;
    overrun_d    = 1'b0;
    pending_d    = pending_q;
    shadow_l_d   = shadow_l_q;
    shadow_r_d   = shadow_r_q;
    active_l_d   = active_l_q;
    active_r_d   = active_r_q;

    if (bclk_fall) begin
      bit_cnt_d = bit_nxt;
      lrclk_d   = lr_nxt;
      dacdat_d  = tx_bit;
    end

    if (frame_load) begin
      sample_req_d = 1'b1;
      if (sample_valid) begin
        active_l_d = audio_left_in;
        active_r_d = audio_right_in;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        active_l_d = shadow_l_q;
        active_r_d = shadow_r_q;
        pending_d  = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end else if (sample_valid) begin
      shadow_l_d = audio_left_in;
      shadow_r_d = audio_right_in;
      pending_d  = 1'b1;
      overrun_d  = pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= BIT_LAST;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      dacdat_q     <= 1'b0;
      sample_req_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
      pending_q    <= 1'b0;
      shadow_l_q   <= '0;
      shadow_r_q   <= '0;
      active_l_q   <= '0;
      active_r_q   <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      dacdat_q     <= dacdat_d;
      sample_req_q <= sample_req_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
      pending_q    <= pending_d;
      shadow_l_q   <= shadow_l_d;
      shadow_r_q   <= shadow_r_d;
      active_l_q   <= active_l_d;
      active_r_q   <= active_r_d;
    end
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign dacdat     = dacdat_q;
  assign sample_req = sample_req_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: cycle-count model of the I2S timing plus a frame-level sample buffer model,
// a serial receiver that rebuilds each frame, and directed literal checks.
module tb_i2s_dac_tx;

  localparam int DW   = 16;
  localparam int SLOT = 32;
  localparam int DIV  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] audio_left_in = '0;
  logic [DW-1:0] audio_right_in = '0;
  logic          bclk, lrclk, dacdat, sample_req, underrun, overrun;

  i2s_dac_tx #(.DATA_WIDTH(DW), .SLOT_BITS(SLOT), .BCLK_DIV(DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .audio_left_in (audio_left_in),
    .audio_right_in(audio_right_in),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .dacdat        (dacdat),
    .sample_req    (sample_req),
    .underrun      (underrun),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: n counts clk edges since reset release; a frame holds one pair chosen at its load.
  int            mdl_n = 0;
  logic          mdl_on = 1'b0;
  logic [DW-1:0] m_al = '0, m_ar = '0, m_sl = '0, m_sr = '0;
  logic          m_pend = 1'b0, m_req = 1'b0, m_und = 1'b0, m_ovr = 1'b0;

  always @(posedge clk) begin
    mdl_on = 1'b1;
    m_req = 1'b0;
    m_und = 1'b0;
    m_ovr = 1'b0;
    if (reset) begin
      mdl_n = 0;
      m_al = '0; m_ar = '0; m_sl = '0; m_sr = '0;
      m_pend = 1'b0;
    end else begin
      mdl_n++;
      if (mdl_n % (2 * DIV) == 0 && ((mdl_n / (2 * DIV) - 1) % (2 * SLOT)) == 0) begin
        m_req = 1'b1;
        if (sample_valid) begin
          m_al = audio_left_in; m_ar = audio_right_in; m_pend = 1'b0;
        end else if (m_pend) begin
          m_al = m_sl; m_ar = m_sr; m_pend = 1'b0;
        end else begin
          m_und = 1'b1;
        end
      end else if (sample_valid) begin
        m_ovr = m_pend;
        m_sl = audio_left_in; m_sr = audio_right_in; m_pend = 1'b1;
      end
    end
  end

  int            e_f, e_bit, e_p;
  logic          e_bclk, e_lr, e_dat;
  logic [DW-1:0] e_w;
  logic          rx_prev_b = 1'b0, rx_prev_lr = 1'b1, rx_have_l = 1'b0;
  int            rx_pos = 0;
  logic [DW-1:0] rx_w = '0, rx_l = '0;
  logic [31:0]   rxq[$];
  int            und_cnt = 0, ovr_cnt = 0;

  always @(negedge clk) begin
    if (mdl_on) begin
      e_f    = mdl_n / (2 * DIV);
      e_bclk = ((mdl_n / DIV) % 2) == 1;
      e_lr   = 1'b0;
      e_dat  = 1'b0;
      if (e_f > 0) begin
        e_bit = (e_f - 1) % (2 * SLOT);
        e_lr  = e_bit >= SLOT;
        e_p   = e_bit % SLOT;
        e_w   = e_lr ? m_ar : m_al;
        if (e_p >= 1 && e_p <= DW) e_dat = e_w[DW - e_p];
      end
      check("bclk", bclk, e_bclk);
      check("lrclk", lrclk, e_lr);
      check("dacdat", dacdat, e_dat);
      check("sample_req", sample_req, m_req);
      check("underrun", underrun, m_und);
      check("overrun", overrun, m_ovr);
    end
    if (underrun === 1'b1) und_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    // Receiver keyed on falling BCLK, aligned to LRCLK transitions.
    if (reset) begin
      rx_prev_b = 1'b0; rx_prev_lr = 1'b1; rx_pos = 0; rx_have_l = 1'b0;
    end else begin
      if (rx_prev_b && !bclk) begin
        if (lrclk != rx_prev_lr) rx_pos = 0;
        else rx_pos++;
        rx_prev_lr = lrclk;
        if (rx_pos >= 1 && rx_pos <= DW) rx_w = {rx_w[DW-2:0], dacdat};
        if (rx_pos == DW) begin
          if (!lrclk) begin
            rx_l = rx_w; rx_have_l = 1'b1;
          end else if (rx_have_l) begin
            rxq.push_back({rx_l, rx_w}); rx_have_l = 1'b0;
          end
        end
      end
      rx_prev_b = bclk;
    end
  end

  task automatic wait_n(input int k);
    int guard = 0;
    while (mdl_n < k && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (mdl_n < k) begin
      checks++;
      failures++;
      $display("FAIL wait_n timeout: reached %0d required %0d", mdl_n, k);
    end
  endtask

  task automatic strobe_at(input int k, input logic [DW-1:0] l, input logic [DW-1:0] r);
    wait_n(k - 1);
    audio_left_in = l;
    audio_right_in = r;
    sample_valid = 1'b1;
    wait_n(k);
    sample_valid = 1'b0;
  endtask

  logic [31:0] exp_rx [9] = '{32'h0000_0000, 32'hA5C3_8001, 32'hA5C3_8001, 32'hA5C3_8001,
                              32'hA5C3_8001, 32'h0F0F_F0F0, 32'h7FFF_0000, 32'h0000_0000,
                              32'h0000_0000};
  int u0, o0;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_dacdat", dacdat, 0);
    check("rst_req", sample_req, 0);
    reset = 1'b0;

    wait_n(3); check("t1_bclk_c3", bclk, 0);
    wait_n(4); check("t1_bclk_c4", bclk, 1);
    wait_n(7); check("t1_bclk_c7", bclk, 1);
    wait_n(8);
    check("t1_bclk_c8", bclk, 0);
    check("t1_req_c8", sample_req, 1);
    check("t1_und_c8", underrun, 1);
    check("t1_lr_c8", lrclk, 0);

    strobe_at(100, 16'hA5C3, 16'h8001);
    check("t2_ovr", overrun, 0);
    wait_n(520);
    check("t2_req", sample_req, 1);
    check("t2_und", underrun, 0);

    wait_n(600); u0 = und_cnt;
    wait_n(2100); check("t3_und_count", und_cnt - u0, 3);

    wait_n(2101); o0 = ovr_cnt;
    strobe_at(2150, 16'h1234, 16'h5678);
    strobe_at(2250, 16'h0F0F, 16'hF0F0);
    check("t4_ovr_pulse", overrun, 1);
    wait_n(2567); check("t4_ovr_count", ovr_cnt - o0, 1);
    wait_n(2568); check("t4_und", underrun, 0);

    strobe_at(3080, 16'h7FFF, 16'h0000);
    check("t5_req", sample_req, 1);
    check("t5_und", underrun, 0);
    check("t5_ovr", overrun, 0);

    strobe_at(3700, 16'h1111, 16'h2222);
    check("t6_ovr", overrun, 0);
    wait_n(3903);
    check("t6_pre_bclk", bclk, 1);
    check("t6_pre_lrclk", lrclk, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_bclk", bclk, 0);
    check("t6_lrclk", lrclk, 0);
    check("t6_dacdat", dacdat, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_n(8);
    check("t6_req", sample_req, 1);
    check("t6_und", underrun, 1);
    wait_n(1100);

    check("rx_frames", rxq.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < rxq.size()) check($sformatf("rx_frame%0d", i), rxq[i], exp_rx[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
